pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush/bubble control with mul/div wait and perf counters
module pipeline_hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             ex_md_start,
  input  logic             md_done,
  input  logic             dmem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_bubble,
  output logic             exmem_stall,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

  typedef enum logic [1:0] {RUN, MDWAIT, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          load_use;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // A busy data memory freezes the whole pipe and the FSM, even during reset.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_bubble = 1'b0;
    exmem_stall = 1'b0;
    md_timeout  = 1'b0;
    state_nxt   = state;
    tcnt_nxt    = tcnt;
    if (dmem_busy) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
    end else if (!rst) begin
      case (state)
        RUN: begin
          if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nxt   = FLUSH;
          end else if (ex_md_start) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            state_nxt  = MDWAIT;
            tcnt_nxt   = '0;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        MDWAIT: begin
          if (md_done) begin
            state_nxt = RUN;
          end else if (tcnt == TW'(MD_TIMEOUT - 1)) begin
            md_timeout = 1'b1;
            state_nxt  = RUN;
          end else begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            tcnt_nxt   = tcnt + 1'b1;
          end
        end
        FLUSH: begin
          // EX holds a bubble here, so only a new taken branch matters.
          if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      tcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      if (pc_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_br_taken = 0;
  logic ex_md_start = 0, md_done = 0, dmem_busy = 0;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, md_timeout;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_stall, s_idex_bubble, s_exmem_stall, s_md_timeout;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(16), .MD_TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .ex_md_start(ex_md_start),
    .md_done(md_done), .dmem_busy(dmem_busy), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_stall(idex_stall),
    .idex_bubble(idex_bubble), .exmem_stall(exmem_stall), .md_timeout(md_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  // Narrow-counter copy so flush and stall saturation are reached often.
  pipeline_hazard_ctrl #(.CNT_W(4), .MD_TIMEOUT(TMO)) u_small (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .ex_md_start(ex_md_start),
    .md_done(md_done), .dmem_busy(dmem_busy), .pc_stall(s_pc_stall),
    .ifid_stall(s_ifid_stall), .ifid_flush(s_ifid_flush), .idex_stall(s_idex_stall),
    .idex_bubble(s_idex_bubble), .exmem_stall(s_exmem_stall), .md_timeout(s_md_timeout),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  typedef struct {
    logic rst, use1, use2, mem_read, br, md_start, md_done, busy;
    logic [4:0] rs1, rs2, rd;
  } stim_t;

  // ctl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, md_timeout}
  typedef struct packed {
    logic [6:0]  ctl;
    logic [15:0] sc, fc;
    logic [3:0]  ssc, sfc;
  } exp_t;

  exp_t exp_q[$];
  int compared = 0, mismatched = 0, cyc = 0;

  // Reference model: mode 0=running, 1=waiting on mul/div, 2=one-cycle post-branch
  int m_mode = 0, m_wait = 0, m_stall = 0, m_flush = 0;

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : v[15:0];
  endfunction
  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  task automatic model_step(input stim_t s, output exp_t e);
    logic [6:0] c;
    bit hz;
    c  = 7'b0;
    hz = s.mem_read && s.rd != 0 && ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
    if (s.rst) begin
      m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end
    if (s.busy) c = 7'b1101010;
    else if (!s.rst) begin
      if (m_mode == 0) begin
        if (s.br) begin c = 7'b0010100; m_mode = 2; end
        else if (s.md_start) begin c = 7'b1101000; m_mode = 1; m_wait = 0; end
        else if (hz) c = 7'b1100100;
      end else if (m_mode == 1) begin
        if (s.md_done) m_mode = 0;
        else if (m_wait == TMO - 1) begin c = 7'b0000001; m_mode = 0; end
        else begin c = 7'b1101000; m_wait++; end
      end else begin
        if (s.br) c = 7'b0010100;
        else m_mode = 0;
      end
    end
    e.ctl = c;
    e.sc  = sat16(m_stall);
    e.fc  = sat16(m_flush);
    e.ssc = sat4(m_stall);
    e.sfc = sat4(m_flush);
    if (!s.rst) begin
      m_stall += int'(c[6]);
      m_flush += int'(c[4]);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; id_use_rs1 = s.use1; id_use_rs2 = s.use2;
    ex_rd = s.rd; ex_mem_read = s.mem_read; ex_br_taken = s.br; ex_md_start = s.md_start;
    md_done = s.md_done; dmem_busy = s.busy;
    model_step(s, e);
    exp_q.push_back(e);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) drive(idle());
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, a;
      e = exp_q.pop_front();
      a.ctl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, md_timeout};
      a.sc = stall_cnt; a.fc = flush_cnt; a.ssc = s_stall_cnt; a.sfc = s_flush_cnt;
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL cyc%0d outputs: ctl got %b want %b, stall_cnt got %0d want %0d, flush_cnt got %0d want %0d, small got %0d/%0d want %0d/%0d",
                 cyc, a.ctl, e.ctl, a.sc, e.sc, a.fc, e.fc, a.ssc, a.sfc, e.ssc, e.sfc);
      end
      cyc++;
    end
  end

  initial begin
    stim_t s;
    s = idle(); s.rst = 1;
    drive(s); drive(s);
    // load-use, then the same pattern with x0
    s = idle(); s.mem_read = 1; s.rd = 5; s.rs1 = 5; s.use1 = 1;
    drive(s); idle_n(1);
    s.rd = 0; s.rs1 = 0;
    drive(s); idle_n(1);
    // taken branch over a load-use, then load-use during FLUSH is suppressed
    s = idle(); s.br = 1; s.mem_read = 1; s.rd = 5; s.rs1 = 5; s.use1 = 1;
    drive(s);
    s.br = 0;
    drive(s); idle_n(1);
    // mul/div finishing after 5 wait cycles
    s = idle(); s.md_start = 1; drive(s);
    idle_n(5);
    s = idle(); s.md_done = 1; drive(s);
    idle_n(2);
    // timeout with no md_done
    s = idle(); s.md_start = 1; drive(s);
    idle_n(TMO + 2);
    // dmem_busy during MDWAIT freezes the timeout count
    s = idle(); s.md_start = 1; drive(s);
    idle_n(2);
    s = idle(); s.busy = 1; drive(s); drive(s); drive(s);
    idle_n(TMO + 2);
    // reset mid-MDWAIT aborts the wait
    s = idle(); s.md_start = 1; drive(s);
    idle_n(2);
    s = idle(); s.rst = 1; drive(s);
    s = idle(); s.br = 1; s.rst = 1; drive(s);
    idle_n(3);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      s.rst      = ($urandom_range(0, 199) == 0);
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.rd       = 5'($urandom_range(0, 3));
      s.use1     = 1'($urandom);
      s.use2     = 1'($urandom);
      s.mem_read = 1'($urandom);
      s.br       = ($urandom_range(0, 7) == 0);
      s.md_start = ($urandom_range(0, 7) == 0);
      s.md_done  = ($urandom_range(0, 5) == 0);
      s.busy     = ($urandom_range(0, 7) == 0);
      drive(s);
    end
    // saturate the 16-bit stall counter, then one more load-use stall
    s = idle(); s.rst = 1; drive(s);
    s = idle(); s.busy = 1;
    for (int i = 0; i < 65538; i++) drive(s);
    s = idle(); s.mem_read = 1; s.rd = 7; s.rs2 = 7; s.use2 = 1;
    drive(s); drive(s);
    idle_n(2);
    @(posedge clk);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
